sub_stream: RTL
===============

// Module: sub_stream
// PURPOSE
//  Registered signed subtractor for the datapath: diff = a - b on dim-bit two's-complement operands.
//  Inverse-direction companion of the registered adder; recovers an operand from a sum (b = sum - a).
//  Carries a valid/ready stream on both sides with a 2-entry output buffer so that backpressure
//  from downstream never drops a result. Also provides an overflow flag and an overflow event counter.
// PARAMETERS
//  dim      14  operand/result width, bits (two's complement), >= 2
//  cnt_w    16  width of overflow event counter ovf_cnt, >= 1
// PORTS
//  clk        in   1       rising-edge clock, single domain
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       a/b valid this cycle
//  in_ready   out  1       block can accept a/b this cycle
//  a          in   dim     minuend, signed
//  b          in   dim     subtrahend, signed
//  out_valid  out  1       diff/ovf valid (head of buffer)
//  out_ready  in   1       downstream consumes head this cycle
//  diff       out  dim     result, signed
//  ovf        out  1       signed overflow of the result at head
//  ovf_cnt    out  cnt_w   number of accepted operations that overflowed, saturating
//  ovf_clr    in   1       synchronous clear of ovf_cnt
// BEHAVIOUR
//  - Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
//  - Full difference: fulldiff[dim:0] = sext(a) - sext(b), exact in dim+1 bits.
//  - ovf = (fulldiff[dim] != fulldiff[dim-1]). Without saturation: diff = fulldiff[dim-1:0] (wrap).
//  - Buffer: 2 entries {diff, ovf}, in-order, occupancy count 0..2.
//  - in_ready = (count != 2). Registered-state only; no combinational path from out_ready.
//  - out_valid = (count != 0); diff/ovf show the head entry and hold stable while out_valid && !out_ready.
//  - Latency: accepted operands appear at out_valid on the next cycle (count 0 -> 1).
//  - Simultaneous accept and pop: count unchanged; order preserved. At count=2 no accept occurs,
//    even if out_ready=1 in the same cycle (throughput 1/cycle sustained for count<=1).
//  - Pop at count=0 and accept at count=2 cannot occur (gated by out_valid/in_ready).
//  - ovf_cnt increments by 1 on each accept whose ovf=1, regardless of the output mode.
//    It holds at all-ones (no wrap). ovf_clr=1 sets it to 0 and takes priority over an increment
//    in the same cycle.
//  - Reset (any time, including mid-stream): count=0, buffer contents dropped, out_valid=0,
//    in_ready=1 from the first cycle after reset, diff=0, ovf=0, ovf_cnt=0. Inputs are ignored
//    while rst=1.
//  - Bounds, dim=14: a,b in -8192..8191; fulldiff in -16383..16383.
// CONFIGURATION
//  SUB_STREAM_SATURATE_EN defined:
//  - On ovf=1, diff clamps to +max (0..01..1) if fulldiff[dim]=0, else to -min (10..0).
//  - ovf is still reported as computed from fulldiff.
//  SUB_STREAM_SATURATE_EN undefined:
//  - diff is the wrapped low dim bits; ovf and ovf_cnt are unchanged.
// TESTING (dim=14, cnt_w=16)
//  - Reset then single op a=100, b=30, out_ready=1 -> out_valid one cycle later, diff=70, ovf=0;
//    then out_valid=0.
//  - a=8191, b=-1 -> ovf=1, ovf_cnt=1; diff=-8192 (0x2000) without macro,
//    diff=8191 (0x1FFF) with SUB_STREAM_SATURATE_EN.
//  - a=-8192, b=1 -> ovf=1; diff=8191 (0x1FFF) wrap; diff=-8192 (0x2000) saturated.
//  - out_ready=0, push 3 ops (5-1, 6-2, 7-3) -> 2 accepted, in_ready=0 after the 2nd, third held.
//    Release -> outputs 4, 4, 4 in order, none lost.
//  - Continuous in_valid=1, out_ready=1 for 100 random ops -> one result/cycle in order,
//    matching a golden model.
//  - Assert rst with count=2 and ovf_cnt=3 -> next cycle out_valid=0, in_ready=1, ovf_cnt=0;
//    ovf_clr coincident with an ovf accept -> ovf_cnt=0.

Source files
------------

// File: rtl/sub_stream.sv
// rtl/sub_stream.sv - registered signed subtractor with a 2-entry valid/ready output buffer
//
// Purpose:
//   Computes diff = a - b on dim-bit two's-complement operands and reports signed overflow.
//   Each accepted operation is stored in a 2-entry in-order buffer. Downstream backpressure
//   stalls the input side and never drops a result. ovf_cnt counts accepted operations that
//   overflowed and saturates at all-ones.
//
// Configuration macro:
//   SUB_STREAM_SATURATE_EN - when defined, an overflowing result clamps to +max or -min.
//                            Without it the result wraps to the low dim bits.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a/b valid this cycle
//   in_ready   out  1      block can accept a/b this cycle (buffer not full)
//   a          in   dim    minuend, signed
//   b          in   dim    subtrahend, signed
//   out_valid  out  1      head of buffer valid
//   out_ready  in   1      downstream consumes head this cycle
//   diff       out  dim    result at head, signed
//   ovf        out  1      signed overflow of the result at head
//   ovf_cnt    out  cnt_w  saturating count of accepted operations that overflowed
//   ovf_clr    in   1      synchronous clear of ovf_cnt (wins over an increment)
module sub_stream #(
  parameter int dim   = 14,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dim-1:0]   a,
  input  logic [dim-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dim-1:0]   diff,
  output logic             ovf,
  output logic [cnt_w-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  // One extra bit makes the difference exact; overflow shows up as the top two bits disagreeing.
  logic [dim:0]   fulldiff;
  logic           new_ovf;
  logic [dim-1:0] new_diff;

  assign fulldiff = {a[dim-1], a} - {b[dim-1], b};
  assign new_ovf  = fulldiff[dim] ^ fulldiff[dim-1];

`ifdef SUB_STREAM_SATURATE_EN
  localparam logic [dim-1:0] SAT_MAX = {1'b0, {(dim-1){1'b1}}};
  localparam logic [dim-1:0] SAT_MIN = {1'b1, {(dim-1){1'b0}}};

  always_comb begin
    new_diff = fulldiff[dim-1:0];
    if (new_ovf) begin
      new_diff = fulldiff[dim] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    new_diff = fulldiff[dim-1:0];
  end
`endif

  // The head entry drives the outputs directly. The tail entry is only used when two results are held.
  logic [1:0]       count_q,     count_d;
  logic [dim-1:0]   head_diff_q, head_diff_d;
  logic             head_ovf_q,  head_ovf_d;
  logic [dim-1:0]   tail_diff_q, tail_diff_d;
  logic             tail_ovf_q,  tail_ovf_d;
  logic [cnt_w-1:0] ovf_cnt_q,   ovf_cnt_d;

  logic accept;
  logic pop;

  // Both handshake signals come from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign diff      = head_diff_q;
  assign ovf       = head_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    head_diff_d = head_diff_q;
    head_ovf_d  = head_ovf_q;
    tail_diff_d = tail_diff_q;
    tail_ovf_d  = tail_ovf_q;

    if (accept && !pop) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_diff_d = new_diff;
        head_ovf_d  = new_ovf;
      end else begin
        tail_diff_d = new_diff;
        tail_ovf_d  = new_ovf;
      end
    end else if (pop && !accept) begin
      count_d     = count_q - 2'd1;
      head_diff_d = tail_diff_q;
      head_ovf_d  = tail_ovf_q;
    end else if (pop && accept) begin
      // Accepting requires count < 2 and popping requires count > 0, so count is 1 here.
      // The new result replaces the head directly.
      head_diff_d = new_diff;
      head_ovf_d  = new_ovf;
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (accept && new_ovf && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      head_diff_q <= '0;
      head_ovf_q  <= 1'b0;
      tail_diff_q <= '0;
      tail_ovf_q  <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      count_q     <= count_d;
      head_diff_q <= head_diff_d;
      head_ovf_q  <= head_ovf_d;
      tail_diff_q <= tail_diff_d;
      tail_ovf_q  <= tail_ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

endmodule
